// File: rtl/input_mem_ctrl.sv
// -----------------------------------------------------------------------------
// input_mem_ctrl
//
// Sequencer for the 192-byte input pixel buffer (64 BGR pixels, 3 bytes each).
// A block runs IDLE -> FILL -> DRAIN -> DONE -> IDLE.
//
// FILL:  each 32-bit AHB read beat is written into four consecutive buffer
//        bytes. The buffer write strobe and four byte addresses come from here.
// DRAIN: the 64 pixel slots are walked in order. Each slot presents its B/G/R
//        read addresses and a PAD flag for slots at or beyond the latched
//        image width.
//
// Handshake (DRAIN side): a slot issues on any cycle with state==DRAIN and
// I_IMC_PIX_READY=1. The read addresses and PAD are combinational from the
// slot counter, so the buffer samples them on that same clock edge.
// O_IMC_PIX_VALID rises one cycle later, together with O_IMC_PIX_IDX for that
// slot. The consumer must take the data on every PIX_VALID cycle; there is no
// back-pressure on the valid cycle itself. On the FILL side, I_IMC_RVALID
// qualifies one beat per cycle while O_IMC_RREQ is high.
//
// Ports
//   I_IMC_HCLK                 clock
//   I_IMC_HRESET_N             synchronous active-low reset
//   I_IMC_START                start one block (accepted only in IDLE)
//   I_IMC_WIDTH[6:0]           valid pixels 1..64 (0 means 64), latched on START
//   O_IMC_RREQ                 request AHB read beats (high throughout FILL)
//   I_IMC_RVALID               read beat valid this cycle
//   O_IMC_WRITE                buffer write strobe
//   O_IMC_PIXEL_IN_ADDR0..3    byte write addresses for RDATA bytes 0..3
//   O_IMC_PIXEL_OUT_ADDRB/G/R  byte read addresses of the current slot
//   O_IMC_PAD                  current read slot is padding
//   I_IMC_PIX_READY            core can accept a pixel next cycle
//   O_IMC_PIX_VALID            buffer pixel outputs valid this cycle
//   O_IMC_PIX_IDX[5:0]         slot index of the pixel flagged by PIX_VALID
//   O_IMC_BUSY                 state != IDLE
//   O_IMC_DONE                 one-cycle pulse, block complete
//   O_IMC_DBG_STATE[1:0]       current FSM state (debug visibility)
// -----------------------------------------------------------------------------
module input_mem_ctrl #(
    parameter int DEPTH_BYTES = 192,
    parameter int PIX_PER_BLK = 64,
    parameter int ADDR_W      = 8
) (
    input  logic              I_IMC_HCLK,
    input  logic              I_IMC_HRESET_N,
    input  logic              I_IMC_START,
    input  logic [6:0]        I_IMC_WIDTH,
    output logic              O_IMC_RREQ,
    input  logic              I_IMC_RVALID,
    output logic              O_IMC_WRITE,
    output logic [ADDR_W-1:0] O_IMC_PIXEL_IN_ADDR0,
    output logic [ADDR_W-1:0] O_IMC_PIXEL_IN_ADDR1,
    output logic [ADDR_W-1:0] O_IMC_PIXEL_IN_ADDR2,
    output logic [ADDR_W-1:0] O_IMC_PIXEL_IN_ADDR3,
    output logic [ADDR_W-1:0] O_IMC_PIXEL_OUT_ADDRB,
    output logic [ADDR_W-1:0] O_IMC_PIXEL_OUT_ADDRG,
    output logic [ADDR_W-1:0] O_IMC_PIXEL_OUT_ADDRR,
    output logic              O_IMC_PAD,
    input  logic              I_IMC_PIX_READY,
    output logic              O_IMC_PIX_VALID,
    output logic [5:0]        O_IMC_PIX_IDX,
    output logic              O_IMC_BUSY,
    output logic              O_IMC_DONE,
    output logic [1:0]        O_IMC_DBG_STATE
);

    // Bytes per pixel slot (3 for BGR).
    localparam int PIX_BYTES = DEPTH_BYTES / PIX_PER_BLK;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FILL  = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    state_t            r_state;
    state_t            w_next_state;

    logic [6:0]        r_width;      // effective width, 1..64
    logic [5:0]        r_beat;       // accepted beats in this FILL
    logic [ADDR_W-1:0] r_waddr;      // byte address of the next beat
    logic [5:0]        r_slot;       // DRAIN slot counter p
    logic              r_pix_valid;
    logic [5:0]        r_pix_idx;

    logic [6:0]        w_width_eff;
    logic [8:0]        w_width_bytes;
    logic [5:0]        w_nbeats;
    logic              w_beat_acc;
    logic              w_last_beat;
    logic              w_issue;
    logic              w_last_slot;

    // A WIDTH of 0 means a full block.
    assign w_width_eff = (I_IMC_WIDTH == 7'd0) ? 7'd64 : I_IMC_WIDTH;

    // NBEATS = ceil(3*W/4). A partial last beat still writes all four bytes.
    // The top byte stays within the buffer because 3*64 is a multiple of 4.
    assign w_width_bytes = 9'(PIX_BYTES * r_width) + 9'd3;
    assign w_nbeats      = w_width_bytes[7:2];

    assign w_beat_acc  = (r_state == ST_FILL) && I_IMC_RVALID;
    assign w_last_beat = (r_beat == (w_nbeats - 6'd1));
    assign w_issue     = (r_state == ST_DRAIN) && I_IMC_PIX_READY;
    assign w_last_slot = (r_slot == 6'(PIX_PER_BLK - 1));

    // -------------------------------------------------------------------------
    // FSM state register
    // -------------------------------------------------------------------------
    always_ff @(posedge I_IMC_HCLK) begin
        if (!I_IMC_HRESET_N) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // -------------------------------------------------------------------------
    // FSM next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE: begin
                if (I_IMC_START) begin
                    w_next_state = ST_FILL;
                end
            end
            ST_FILL: begin
                if (w_beat_acc && w_last_beat) begin
                    w_next_state = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (w_issue && w_last_slot) begin
                    w_next_state = ST_DONE;
                end
            end
            ST_DONE: begin
                w_next_state = ST_IDLE;
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Counters and registered outputs
    // -------------------------------------------------------------------------
    always_ff @(posedge I_IMC_HCLK) begin
        if (!I_IMC_HRESET_N) begin
            r_width     <= 7'd0;
            r_beat      <= 6'd0;
            r_waddr     <= '0;
            r_slot      <= 6'd0;
            r_pix_valid <= 1'b0;
            r_pix_idx   <= 6'd0;
        end else begin
            // Width is captured only when a block is actually accepted.
            if ((r_state == ST_IDLE) && I_IMC_START) begin
                r_width <= w_width_eff;
                r_beat  <= 6'd0;
                r_waddr <= '0;
                r_slot  <= 6'd0;
            end

            // RVALID gaps simply hold the fill counters.
            if (w_beat_acc) begin
                r_beat  <= r_beat + 6'd1;
                r_waddr <= r_waddr + ADDR_W'(4);
            end

            // PIX_READY low holds the slot, so the buffer re-reads it.
            if (w_issue) begin
                r_slot    <= r_slot + 6'd1;
                r_pix_idx <= r_slot;
            end

            // The buffer read is registered, so valid trails the issue by one.
            r_pix_valid <= w_issue;
        end
    end

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    always_comb begin
        O_IMC_PIXEL_IN_ADDR0  = '0;
        O_IMC_PIXEL_IN_ADDR1  = '0;
        O_IMC_PIXEL_IN_ADDR2  = '0;
        O_IMC_PIXEL_IN_ADDR3  = '0;
        O_IMC_PIXEL_OUT_ADDRB = '0;
        O_IMC_PIXEL_OUT_ADDRG = '0;
        O_IMC_PIXEL_OUT_ADDRR = '0;
        O_IMC_PAD             = 1'b0;

        if (r_state == ST_FILL) begin
            O_IMC_PIXEL_IN_ADDR0 = r_waddr;
            O_IMC_PIXEL_IN_ADDR1 = r_waddr + ADDR_W'(1);
            O_IMC_PIXEL_IN_ADDR2 = r_waddr + ADDR_W'(2);
            O_IMC_PIXEL_IN_ADDR3 = r_waddr + ADDR_W'(3);
        end

        if (r_state == ST_DRAIN) begin
            O_IMC_PIXEL_OUT_ADDRB = ADDR_W'(PIX_BYTES * r_slot);
            O_IMC_PIXEL_OUT_ADDRG = ADDR_W'(PIX_BYTES * r_slot + 1);
            O_IMC_PIXEL_OUT_ADDRR = ADDR_W'(PIX_BYTES * r_slot + 2);
            O_IMC_PAD             = ({1'b0, r_slot} >= r_width);
        end
    end

    assign O_IMC_RREQ      = (r_state == ST_FILL);
    assign O_IMC_WRITE     = w_beat_acc;
    assign O_IMC_PIX_VALID = r_pix_valid;
    assign O_IMC_PIX_IDX   = r_pix_idx;
    assign O_IMC_BUSY      = (r_state != ST_IDLE);
    assign O_IMC_DONE      = (r_state == ST_DONE);
    assign O_IMC_DBG_STATE = r_state;

endmodule
